// File: rtl/cache_pkg.sv
// Shared widths, address-field types, FSM state encoding and helpers for the
// 4-way set-associative write-back data cache.
package cache_pkg;

  localparam int PA_WIDTH     = 32;
  localparam int WRD_WIDTH    = 32;
  localparam int BLK_WIDTH    = 512;
  localparam int NWAYS        = 4;
  localparam int NSETS        = 128;
  localparam int OFFSET_WIDTH = 6;
  localparam int INDEX_WIDTH  = 7;
  localparam int TAG_WIDTH    = PA_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WAY_WIDTH    = 2;
  localparam int WSEL_WIDTH   = 4;
  localparam int BSEL_WIDTH   = 2;

  typedef logic [TAG_WIDTH-1:0]   tag_t;
  typedef logic [INDEX_WIDTH-1:0] index_t;
  typedef logic [WAY_WIDTH-1:0]   way_t;
  typedef logic [BLK_WIDTH-1:0]   blk_t;
  typedef logic [NWAYS-1:0][1:0]  ages_t;

  typedef struct packed {
    tag_t                  tag;
    index_t                index;
    logic [WSEL_WIDTH-1:0] word_sel;
    logic [BSEL_WIDTH-1:0] byte_sel;
  } addr_t;

  // Way k starts with age k so the ages of every set are a permutation of 0..3.
  localparam ages_t AGES_RESET = {2'd3, 2'd2, 2'd1, 2'd0};

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITE_BACK,
    S_ALLOCATE
  } state_t;

  function automatic addr_t split_addr(input logic [PA_WIDTH-1:0] a);
    return addr_t'(a);
  endfunction

  function automatic logic [PA_WIDTH-1:0] block_addr(input tag_t t, input index_t i);
    return {t, i, {OFFSET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_control_unit_if.sv
// CPU load/store port plus block-wide memory port of the data cache.
interface cache_control_unit_if;
  import cache_pkg::*;

  logic [PA_WIDTH-1:0]  addr;
  logic [WRD_WIDTH-1:0] data_wr;
  logic                 rd_en;
  logic                 wr_en;
  logic [BLK_WIDTH-1:0] mem_rd_blk;
  logic [PA_WIDTH-1:0]  mem_addr;
  logic                 mem_rd_en;
  logic                 mem_wr_en;
  logic [BLK_WIDTH-1:0] mem_wr_blk;
  logic                 hit;
  logic [WRD_WIDTH-1:0] word_out;
  logic [7:0]           byte_out;

  modport slave (
    input  addr, data_wr, rd_en, wr_en, mem_rd_blk,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_blk, hit, word_out, byte_out
  );

  modport master (
    output addr, data_wr, rd_en, wr_en, mem_rd_blk,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_blk, hit, word_out, byte_out
  );

endinterface

// File: rtl/cache_lru.sv
// Combinational LRU age update and replacement-victim selection for one set.
module cache_lru
  import cache_pkg::*;
(
  input  ages_t            i_ages,
  input  logic [NWAYS-1:0] i_valid,
  input  way_t             i_acc_way,
  output ages_t            o_ages,
  output way_t             o_victim
);

  logic w_found;

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the loops can leave a value held and infer a latch.
  always_comb begin
    o_ages = i_ages;
    for (int k = 0; k < NWAYS; k++) begin
      if (way_t'(k) == i_acc_way) begin
        o_ages[way_t'(k)] = 2'd0;
      end else if (i_ages[way_t'(k)] < i_ages[i_acc_way]) begin
        o_ages[way_t'(k)] = i_ages[way_t'(k)] + 2'd1;
      end
    end
  end

  // Lowest-index invalid way wins; otherwise the oldest (age 3) way.
  always_comb begin
    o_victim = '0;
    w_found  = 1'b0;
    for (int k = 0; k < NWAYS; k++) begin
      if (!w_found && !i_valid[way_t'(k)]) begin
        o_victim = way_t'(k);
        w_found  = 1'b1;
      end
    end
    if (!w_found) begin
      for (int k = 0; k < NWAYS; k++) begin
        if (i_ages[way_t'(k)] == 2'd3) o_victim = way_t'(k);
      end
    end
  end

endmodule

// File: rtl/cache_control_unit.sv
// 4-way, 128-set, write-back/write-allocate data cache: arrays, tag lookup,
// LRU replacement, dirty write-back and block refill.
module cache_control_unit
  import cache_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input logic                 clk,
  input logic                 rst,
  cache_control_unit_if.slave bus
);

  localparam int               CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

  state_t               r_state;
  logic [PA_WIDTH-1:0]  r_addr;
  logic [WRD_WIDTH-1:0] r_wdata;
  logic                 r_is_write;
  way_t                 r_victim;
  logic [CNT_W-1:0]     r_cnt;

  logic [NWAYS-1:0] r_valid [NSETS];
  logic [NWAYS-1:0] r_dirty [NSETS];
  ages_t            r_age   [NSETS];
  tag_t             r_tag   [NWAYS][NSETS];
  blk_t             r_data  [NWAYS][NSETS];

  logic                 r_hit;
  logic                 r_mem_rd_en;
  logic                 r_mem_wr_en;
  logic [PA_WIDTH-1:0]  r_mem_addr;
  blk_t                 r_mem_wr_blk;
  logic [WRD_WIDTH-1:0] r_word_out;
  logic [7:0]           r_byte_out;

  addr_t                w_req;
  logic [NWAYS-1:0]     w_set_valid;
  logic [NWAYS-1:0]     w_set_dirty;
  ages_t                w_set_ages;
  ages_t                w_new_ages;
  logic                 w_hit;
  way_t                 w_hit_way;
  way_t                 w_victim;
  blk_t                 w_hit_blk;
  logic [WRD_WIDTH-1:0] w_hit_word;
  logic [7:0]           w_hit_byte;
  logic                 w_fill;
  logic                 w_write_hit;

  assign w_req       = split_addr(r_addr);
  assign w_set_valid = r_valid[w_req.index];
  assign w_set_dirty = r_dirty[w_req.index];
  assign w_set_ages  = r_age[w_req.index];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int k = 0; k < NWAYS; k++) begin
      if (w_set_valid[way_t'(k)] && (r_tag[way_t'(k)][w_req.index] == w_req.tag)) begin
        w_hit     = 1'b1;
        w_hit_way = way_t'(k);
      end
    end
  end

  cache_lru u_lru (
    .i_ages    (w_set_ages),
    .i_valid   (w_set_valid),
    .i_acc_way (w_hit_way),
    .o_ages    (w_new_ages),
    .o_victim  (w_victim)
  );

  assign w_hit_blk   = r_data[w_hit_way][w_req.index];
  assign w_hit_word  = w_hit_blk[{w_req.word_sel, 5'b0} +: WRD_WIDTH];
  assign w_hit_byte  = w_hit_word[{w_req.byte_sel, 3'b0} +: 8];
  assign w_fill      = (r_state == S_ALLOCATE) && (r_cnt == LAST_CNT);
  assign w_write_hit = (r_state == S_COMPARE) && w_hit && r_is_write;

  // NOTE: tag and data arrays carry no reset; a cleared valid bit makes their
  // contents irrelevant, and resetting 256 Kbit of storage would buy nothing.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[r_victim][w_req.index]  <= w_req.tag;
      r_data[r_victim][w_req.index] <= bus.mem_rd_blk;
    end else if (w_write_hit) begin
      r_data[w_hit_way][w_req.index][{w_req.word_sel, 5'b0} +: WRD_WIDTH] <= r_wdata;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every branch
  // below sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_is_write   <= 1'b0;
      r_victim     <= '0;
      r_cnt        <= '0;
      r_valid      <= '{default: '0};
      r_dirty      <= '{default: '0};
      r_age        <= '{default: AGES_RESET};
      r_hit        <= 1'b0;
      r_mem_rd_en  <= 1'b0;
      r_mem_wr_en  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wr_blk <= '0;
      r_word_out   <= '0;
      r_byte_out   <= '0;
    end else begin
      r_hit <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.rd_en || bus.wr_en) begin
            r_addr     <= bus.addr;
            r_wdata    <= bus.data_wr;
            r_is_write <= bus.wr_en;
            r_state    <= S_COMPARE;
          end
        end

        S_COMPARE: begin
          if (w_hit) begin
            if (r_is_write) begin
              r_dirty[w_req.index][w_hit_way] <= 1'b1;
            end else begin
              r_word_out <= w_hit_word;
              r_byte_out <= w_hit_byte;
            end
            r_age[w_req.index] <= w_new_ages;
            r_hit              <= 1'b1;
            r_state            <= S_IDLE;
          end else begin
            r_victim <= w_victim;
            if (w_set_valid[w_victim] && w_set_dirty[w_victim]) begin
              r_mem_wr_en  <= 1'b1;
              r_mem_addr   <= block_addr(r_tag[w_victim][w_req.index], w_req.index);
              r_mem_wr_blk <= r_data[w_victim][w_req.index];
              r_state      <= S_WRITE_BACK;
            end else begin
              r_mem_rd_en <= 1'b1;
              r_mem_addr  <= block_addr(w_req.tag, w_req.index);
              r_cnt       <= '0;
              r_state     <= S_ALLOCATE;
            end
          end
        end

        S_WRITE_BACK: begin
          r_mem_wr_en <= 1'b0;
          r_mem_rd_en <= 1'b1;
          r_mem_addr  <= block_addr(w_req.tag, w_req.index);
          r_cnt       <= '0;
          r_state     <= S_ALLOCATE;
        end

        S_ALLOCATE: begin
          if (r_cnt == LAST_CNT) begin
            r_mem_rd_en                    <= 1'b0;
            r_valid[w_req.index][r_victim] <= 1'b1;
            r_dirty[w_req.index][r_victim] <= 1'b0;
            r_state                        <= S_COMPARE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.hit        = r_hit;
  assign bus.mem_rd_en  = r_mem_rd_en;
  assign bus.mem_wr_en  = r_mem_wr_en;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wr_blk = r_mem_wr_blk;
  assign bus.word_out   = r_word_out;
  assign bus.byte_out   = r_byte_out;

endmodule

// File: tb/tb_cache_control_unit.sv
// Directed bench for cache_control_unit: hits, clean/dirty misses, LRU
// eviction order, simultaneous rd/wr and reset during refill.
module tb_cache_control_unit;

  localparam int L = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_control_unit_if bus ();

  cache_control_unit #(.MEM_LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: unwritten blocks hold the byte address of each word.
  logic [511:0] mem_model [logic [31:0]];
  int           n_rd = 0;
  int           n_wr = 0;
  int           n_both = 0;
  logic [31:0]  last_rd_addr = '0;
  logic [31:0]  last_wr_addr = '0;
  logic [511:0] last_wr_blk = '0;

  function automatic logic [511:0] pat_blk(input logic [31:0] a);
    logic [511:0] b;
    for (int w = 0; w < 16; w++) b[w*32 +: 32] = a + 32'(w * 4);
    return b;
  endfunction

  function automatic logic [511:0] blk_for(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return pat_blk(a);
  endfunction

  function automatic logic [31:0] word_of(input logic [511:0] b, input int w);
    return b[w*32 +: 32];
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.mem_rd_en && bus.mem_wr_en) n_both++;
      if (bus.mem_wr_en) begin
        mem_model[bus.mem_addr] = bus.mem_wr_blk;
        last_wr_addr = bus.mem_addr;
        last_wr_blk  = bus.mem_wr_blk;
        n_wr++;
      end
      if (bus.mem_rd_en) begin
        last_rd_addr = bus.mem_addr;
        n_rd++;
      end
    end
  end

  always @(negedge clk) bus.mem_rd_blk = bus.mem_rd_en ? blk_for(bus.mem_addr) : '0;

  int lat;
  int rd0;
  int wr0;

  // lat = cycle index of the hit pulse counted from the request edge n
  // (n+2 for a hit); 0 when no hit appears within the budget.
  task automatic do_req(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d);
    @(negedge clk);
    rd0 = n_rd;
    wr0 = n_wr;
    bus.addr    = a;
    bus.data_wr = d;
    bus.rd_en   = rd;
    bus.wr_en   = wr;
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.hit) begin
        lat = c + 1;
        break;
      end
    end
  endtask

  logic [511:0] pre_blk;
  logic [31:0]  fill_addrs [3];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    pre_blk = pat_blk(32'h1040);
    pre_blk[63:32] = 32'hDEADBEEF;
    mem_model[32'h1040] = pre_blk;

    rst = 1'b1;
    bus.addr = '0; bus.data_wr = '0; bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    #1;
    check("rst_hit", bus.hit, 0);
    check("rst_mem_rd_en", bus.mem_rd_en, 0);
    check("rst_mem_wr_en", bus.mem_wr_en, 0);
    check("rst_word_out", bus.word_out, 0);
    check("rst_byte_out", bus.byte_out, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wr_blk", bus.mem_wr_blk[63:0], 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Cold read miss
    do_req(32'h0000_1044, 1'b1, 1'b0, '0);
    check("cold_lat", lat, 3 + L);
    check("cold_rd_addr", last_rd_addr, 32'h0000_1040);
    check("cold_rd_cycles", n_rd - rd0, L);
    check("cold_no_wb", n_wr - wr0, 0);
    check("cold_word", bus.word_out, 32'hDEADBEEF);
    check("cold_byte", bus.byte_out, 8'hEF);

    // Read hit, top byte
    do_req(32'h0000_1047, 1'b1, 1'b0, '0);
    check("rdhit_lat", lat, 2);
    check("rdhit_no_mem", n_rd - rd0, 0);
    check("rdhit_word", bus.word_out, 32'hDEADBEEF);
    check("rdhit_byte", bus.byte_out, 8'hDE);

    // Write hit leaves word_out untouched
    do_req(32'h0000_1044, 1'b0, 1'b1, 32'h1234_5678);
    check("wrhit_lat", lat, 2);
    check("wrhit_no_wb", n_wr - wr0, 0);
    check("wrhit_no_rd", n_rd - rd0, 0);
    check("wrhit_word_hold", bus.word_out, 32'hDEADBEEF);

    do_req(32'h0000_1044, 1'b1, 1'b0, '0);
    check("rdback_lat", lat, 2);
    check("rdback_word", bus.word_out, 32'h1234_5678);
    check("rdback_byte", bus.byte_out, 8'h78);

    // Fill the remaining ways of set 65
    fill_addrs = '{32'h3040, 32'h5040, 32'h7040};
    foreach (fill_addrs[i]) begin
      do_req(fill_addrs[i], 1'b1, 1'b0, '0);
      check("fill_lat", lat, 3 + L);
      check("fill_word", bus.word_out, fill_addrs[i]);
      check("fill_no_wb", n_wr - wr0, 0);
    end

    // Dirty eviction of the 0x1040 line (age 3, way 0)
    do_req(32'h0000_9040, 1'b1, 1'b0, '0);
    check("evict_lat", lat, 4 + L);
    check("evict_wb_count", n_wr - wr0, 1);
    check("evict_wb_addr", last_wr_addr, 32'h0000_1040);
    check("evict_wb_word1", word_of(last_wr_blk, 1), 32'h1234_5678);
    check("evict_wb_word0", word_of(last_wr_blk, 0), 32'h0000_1040);
    check("evict_rd_addr", last_rd_addr, 32'h0000_9040);
    check("evict_word", bus.word_out, 32'h0000_9040);

    // Re-read of the evicted line: clean miss (victim 0x3040), data from memory
    do_req(32'h0000_1044, 1'b1, 1'b0, '0);
    check("reread_lat", lat, 3 + L);
    check("reread_no_wb", n_wr - wr0, 0);
    check("reread_rd_addr", last_rd_addr, 32'h0000_1040);
    check("reread_word", bus.word_out, 32'h1234_5678);

    // rd_en and wr_en together act as a write
    do_req(32'h0000_2000, 1'b1, 1'b1, 32'hCAFE_F00D);
    check("both_lat", lat, 3 + L);
    check("both_word_hold", bus.word_out, 32'h1234_5678);
    do_req(32'h0000_2000, 1'b1, 1'b0, '0);
    check("both_rd_lat", lat, 2);
    check("both_rd_word", bus.word_out, 32'hCAFE_F00D);

    fill_addrs = '{32'h4000, 32'h6000, 32'h8000};
    foreach (fill_addrs[i]) begin
      do_req(fill_addrs[i], 1'b1, 1'b0, '0);
      check("set0_fill_lat", lat, 3 + L);
    end
    do_req(32'h0000_A000, 1'b1, 1'b0, '0);
    check("both_dirty_lat", lat, 4 + L);
    check("both_dirty_wb_addr", last_wr_addr, 32'h0000_2000);
    check("both_dirty_wb_word0", word_of(last_wr_blk, 0), 32'hCAFE_F00D);
    check("both_dirty_word", bus.word_out, 32'h0000_A000);

    // Reset while a refill is in flight
    @(negedge clk);
    bus.addr  = 32'h0000_0080;
    bus.rd_en = 1'b1;
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    @(posedge clk);
    #1;
    check("alloc_rd_en", bus.mem_rd_en, 1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_rd_en", bus.mem_rd_en, 0);
    check("abort_wr_en", bus.mem_wr_en, 0);
    check("abort_hit", bus.hit, 0);
    @(negedge clk);
    rst = 1'b0;

    do_req(32'h0000_0080, 1'b1, 1'b0, '0);
    check("post_rst_lat", lat, 3 + L);
    check("post_rst_rd_cycles", n_rd - rd0, L);
    check("post_rst_word", bus.word_out, 32'h0000_0080);

    check("rd_wr_exclusive", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
